// File: rtl/rc_tag_manager_if.sv
// Signal bundle for rc_tag_manager: tag-allocation handshake, snooped RC completion
// stream, and tag-release / status outputs. master drives the inputs, slave is the manager.
interface rc_tag_manager_if #(
    parameter int TAG_COUNT = 32,
    parameter int TAG_W     = $clog2(TAG_COUNT)
);
    logic             alloc_valid;
    logic [9:0]       alloc_dwlen;
    logic             alloc_ready;
    logic [TAG_W-1:0] alloc_tag;

    logic             rc_tvalid;
    logic             rc_tready;
    logic             rc_tlast;
    logic             rc_sop;
    logic [127:0]     rc_tdata;

    logic             done_valid;
    logic [TAG_W-1:0] done_tag;
    logic             done_err;
    logic             cpl_unexp;
    logic [TAG_W:0]   outstanding;

    modport master (
        output alloc_valid, alloc_dwlen,
        output rc_tvalid, rc_tready, rc_tlast, rc_sop, rc_tdata,
        input  alloc_ready, alloc_tag,
        input  done_valid, done_tag, done_err, cpl_unexp, outstanding
    );

    modport slave (
        input  alloc_valid, alloc_dwlen,
        input  rc_tvalid, rc_tready, rc_tlast, rc_sop, rc_tdata,
        output alloc_ready, alloc_tag,
        output done_valid, done_tag, done_err, cpl_unexp, outstanding
    );
endinterface

// File: rtl/rc_tag_manager.sv
// PCIe read-tag allocator that retires tags by snooping the adapted 128-bit RC completion stream.
// Define RC_TAG_TIMEOUT_EN to add per-tag completion timeouts (TIMEOUT_CYCLES parameter).
module rc_tag_manager #(
    parameter int TAG_COUNT = 32
`ifdef RC_TAG_TIMEOUT_EN
    ,
    parameter int TIMEOUT_CYCLES = 65536
`endif
) (
    input  logic            user_clk,
    input  logic            user_reset_n,
    rc_tag_manager_if.slave bus
);
    localparam int TAG_W = $clog2(TAG_COUNT);
    localparam logic [0:0]     ST_IDLE  = 1'b0;
    localparam logic [0:0]     ST_INPKT = 1'b1;
    localparam logic [TAG_W:0] OUT_ONE  = 1;

    logic [0:0]           state_q, state_d;
    logic [TAG_COUNT-1:0] free_q, free_d;
    logic [10:0]          remaining_q [TAG_COUNT];
    logic [10:0]          remaining_d [TAG_COUNT];
    logic [7:0]           hdr_tag_q, hdr_tag_d;
    logic [10:0]          hdr_len_q, hdr_len_d;
    logic [2:0]           hdr_stat_q, hdr_stat_d;
    logic                 done_valid_q, done_valid_d;
    logic [TAG_W-1:0]     done_tag_q, done_tag_d;
    logic                 done_err_q, done_err_d;
    logic                 cpl_unexp_q, cpl_unexp_d;
    logic [TAG_W:0]       outstanding_q, outstanding_d;

    logic             alloc_ready, alloc_fire;
    logic [TAG_W-1:0] alloc_tag;
    logic             beat, sop_beat, pkt_beat, eval;
    logic [7:0]       cur_tag;
    logic [10:0]      cur_len;
    logic [2:0]       cur_stat;
    logic [TAG_W-1:0] cur_idx;
    logic             cur_hit, cur_busy;
    logic             rel, rel_err;
    logic [TAG_W-1:0] rel_idx;
    logic             unused_tdata;

    // NOTE: every always_comb output gets a default before any branch, otherwise a latch is inferred.
    always_comb begin
        alloc_tag = '0;
        for (int i = TAG_COUNT - 1; i >= 0; i--) begin
            if (free_q[i]) alloc_tag = TAG_W'(i);
        end
    end

    assign alloc_ready = |free_q;
    assign alloc_fire  = bus.alloc_valid & alloc_ready;

    // Header fields come straight off the SOP beat, or from the latched copy later in the packet.
    assign beat     = bus.rc_tvalid & bus.rc_tready;
    assign sop_beat = beat & bus.rc_sop & (state_q == ST_IDLE);
    assign pkt_beat = sop_beat | (beat & (state_q == ST_INPKT));
    assign eval     = pkt_beat & bus.rc_tlast;
    assign cur_tag  = sop_beat ? bus.rc_tdata[79:72] : hdr_tag_q;
    assign cur_len  = sop_beat ? {bus.rc_tdata[9:0] == 10'd0, bus.rc_tdata[9:0]} : hdr_len_q;
    assign cur_stat = sop_beat ? bus.rc_tdata[47:45] : hdr_stat_q;
    assign cur_idx  = cur_tag[TAG_W-1:0];
    assign cur_hit  = (cur_tag >> TAG_W) == 8'd0;
    assign cur_busy = cur_hit & ~free_q[cur_idx];

    assign unused_tdata = ^{bus.rc_tdata[127:80], bus.rc_tdata[71:48], bus.rc_tdata[44:10]};

`ifdef RC_TAG_TIMEOUT_EN
    localparam int TICK_PERIOD = TIMEOUT_CYCLES / 4;
    localparam int PS_W        = $clog2(TICK_PERIOD + 1);

    logic [PS_W-1:0]      presc_q, presc_d;
    logic [1:0]           age_q [TAG_COUNT];
    logic [1:0]           age_d [TAG_COUNT];
    logic [TAG_COUNT-1:0] pend_q, pend_d, to_cand;
    logic                 tick;
    logic [TAG_W-1:0]     to_idx;

    assign tick    = presc_q == PS_W'(TICK_PERIOD - 1);
    assign presc_d = tick ? '0 : presc_q + PS_W'(1);
    assign to_cand = pend_q & ~free_q;

    always_comb begin
        to_idx = '0;
        for (int i = TAG_COUNT - 1; i >= 0; i--) begin
            if (to_cand[i]) to_idx = TAG_W'(i);
        end
    end

    // A queued timeout stays queued until that tag is released or reallocated.
    always_comb begin
        for (int i = 0; i < TAG_COUNT; i++) begin
            age_d[i]  = age_q[i];
            pend_d[i] = pend_q[i];
            if (tick && !free_q[i]) begin
                if (age_q[i] == 2'd3) pend_d[i] = 1'b1;
                else                  age_d[i]  = age_q[i] + 2'd1;
            end
            if (pkt_beat && cur_hit && cur_idx == TAG_W'(i)) age_d[i] = '0;
            if ((rel && rel_idx == TAG_W'(i)) || (alloc_fire && alloc_tag == TAG_W'(i))) begin
                age_d[i]  = '0;
                pend_d[i] = 1'b0;
            end
        end
    end

    always_ff @(posedge user_clk or negedge user_reset_n) begin
        if (!user_reset_n) begin
            presc_q <= '0;
            pend_q  <= '0;
            for (int i = 0; i < TAG_COUNT; i++) age_q[i] <= '0;
        end else begin
            presc_q <= presc_d;
            pend_q  <= pend_d;
            age_q   <= age_d;
        end
    end
`endif

    always_comb begin
        state_d       = state_q;
        hdr_tag_d     = hdr_tag_q;
        hdr_len_d     = hdr_len_q;
        hdr_stat_d    = hdr_stat_q;
        free_d        = free_q;
        remaining_d   = remaining_q;
        done_valid_d  = 1'b0;
        done_err_d    = 1'b0;
        done_tag_d    = done_tag_q;
        cpl_unexp_d   = 1'b0;
        outstanding_d = outstanding_q;
        rel           = 1'b0;
        rel_err       = 1'b0;
        rel_idx       = cur_idx;

        if (sop_beat) begin
            hdr_tag_d  = cur_tag;
            hdr_len_d  = cur_len;
            hdr_stat_d = cur_stat;
            if (!bus.rc_tlast) state_d = ST_INPKT;
        end else if (beat && state_q == ST_INPKT && bus.rc_tlast) begin
            state_d = ST_IDLE;
        end

        if (eval) begin
            if (!cur_busy) begin
                cpl_unexp_d = 1'b1;
            end else if (cur_stat != 3'd0 || cur_len > remaining_q[cur_idx]) begin
                rel     = 1'b1;
                rel_err = 1'b1;
            end else begin
                remaining_d[cur_idx] = remaining_q[cur_idx] - cur_len;
                rel                  = remaining_q[cur_idx] == cur_len;
            end
        end

`ifdef RC_TAG_TIMEOUT_EN
        // Completion releases own the done port; a waiting timeout goes on a free cycle.
        if (!rel && to_cand != '0) begin
            rel     = 1'b1;
            rel_err = 1'b1;
            rel_idx = to_idx;
        end
`endif

        if (rel) begin
            free_d[rel_idx]      = 1'b1;
            remaining_d[rel_idx] = '0;
            done_valid_d         = 1'b1;
            done_tag_d           = rel_idx;
            done_err_d           = rel_err;
        end

        if (alloc_fire) begin
            free_d[alloc_tag]      = 1'b0;
            remaining_d[alloc_tag] = {bus.alloc_dwlen == 10'd0, bus.alloc_dwlen};
        end

        case ({alloc_fire, rel})
            2'b10:   outstanding_d = outstanding_q + OUT_ONE;
            2'b01:   outstanding_d = outstanding_q - OUT_ONE;
            default: outstanding_d = outstanding_q;
        endcase
    end

    // NOTE: state flops use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge user_clk or negedge user_reset_n) begin
        if (!user_reset_n) begin
            state_q       <= ST_IDLE;
            free_q        <= '1;
            hdr_tag_q     <= '0;
            hdr_len_q     <= '0;
            hdr_stat_q    <= '0;
            done_valid_q  <= 1'b0;
            done_tag_q    <= '0;
            done_err_q    <= 1'b0;
            cpl_unexp_q   <= 1'b0;
            outstanding_q <= '0;
            // NOTE: the counter array is small and flop-based, so it is reset rather than left to RAM init.
            for (int i = 0; i < TAG_COUNT; i++) remaining_q[i] <= '0;
        end else begin
            state_q       <= state_d;
            free_q        <= free_d;
            hdr_tag_q     <= hdr_tag_d;
            hdr_len_q     <= hdr_len_d;
            hdr_stat_q    <= hdr_stat_d;
            done_valid_q  <= done_valid_d;
            done_tag_q    <= done_tag_d;
            done_err_q    <= done_err_d;
            cpl_unexp_q   <= cpl_unexp_d;
            outstanding_q <= outstanding_d;
            remaining_q   <= remaining_d;
        end
    end

    assign bus.alloc_ready = alloc_ready;
    assign bus.alloc_tag   = alloc_tag;
    assign bus.done_valid  = done_valid_q;
    assign bus.done_tag    = done_tag_q;
    assign bus.done_err    = done_err_q;
    assign bus.cpl_unexp   = cpl_unexp_q;
    assign bus.outstanding = outstanding_q;
endmodule
